// File: rtl/hdlc_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : hdlc_rx_framer
//  Purpose  : HDLC receive framer. Detects flags and aborts on the raw line,
//             removes stuffed zeros from an 8-bit-delayed copy of the line,
//             assembles LSB-first octets and reports frame boundaries, size
//             and errors.
//  Options  : HDLC_RX_FCS_EN - adds a CRC-16-CCITT check over the kept bits.
//             A frame whose CRC residue is not 0xF0B8 is marked as errored.
//  Revision : 1.0 - initial release
// ============================================================================
module hdlc_rx_framer (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       RxEN,
   output logic [7:0] Rx_Data,
   output logic       Rx_NewByte,
   output logic       Rx_ValidFrame,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortSignal,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic [7:0] Rx_FrameSize
);

   typedef enum logic [0:0] {
      S_HUNT = 1'b0,
      S_OPEN = 1'b1
   } state_t;

   localparam logic [7:0] c_FLAG      = 8'h7E;
   localparam logic [3:0] c_FLAG_BITS = 4'd8;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_win;        // newest bit in [7], oldest in [0]
   logic [3:0]  r_skip;       // delayed bits still belonging to the last flag
   logic [2:0]  r_ones;       // consecutive delayed ones seen by de-stuffer
   logic [6:0]  r_shreg;      // partially assembled octet
   logic [2:0]  r_bitcnt;     // kept bits in the current octet
   logic [7:0]  r_bytecnt;    // octets in the current frame, saturating

   logic [7:0]  r_data;
   logic        r_newbyte;
   logic        r_flagdet;
   logic        r_abortsig;
   logic        r_eof;
   logic        r_err;
   logic [7:0]  r_size;

   logic [7:0]  w_shift;
   logic        w_dbit;
   logic        w_flag;
   logic        w_abort;
   logic        w_use;
   logic        w_keep;
   logic        w_octet;
   logic        w_newbyte;
   logic [7:0]  w_byte_val;
   logic [7:0]  w_bytes_after;
   logic [2:0]  w_bits_after;
   logic        w_fcs_bad;
   logic        w_eof;
   logic        w_err;
   logic        w_abort_pulse;

   // Window and delayed-bit decode. The bit leaving the window is the line
   // bit eight samples old, so when a closing flag is recognised every data
   // bit ahead of it has already been handed to the de-stuffer.
   assign w_shift       = {Rx, r_win[7:1]};
   assign w_dbit        = r_win[0];
   assign w_flag        = RxEN && (w_shift == c_FLAG);
   assign w_abort       = RxEN && (w_shift[7:1] == 7'h7F);
   assign w_use         = RxEN && (r_state == S_OPEN) && (r_skip == 4'd0);
   assign w_keep        = w_use && !(!w_dbit && (r_ones == 3'd5));
   assign w_octet       = w_keep && (r_bitcnt == 3'd7);
   assign w_newbyte     = w_octet && !w_abort;
   assign w_byte_val    = {w_dbit, r_shreg};
   assign w_bytes_after = (w_octet && (r_bytecnt != 8'hFF)) ? r_bytecnt + 8'd1 : r_bytecnt;
   assign w_bits_after  = w_keep ? r_bitcnt + 3'd1 : r_bitcnt;

`ifdef HDLC_RX_FCS_EN
   logic [15:0] r_crc;
   logic [15:0] w_crc_nxt;

   assign w_crc_nxt = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_dbit) ? 16'h8408 : 16'h0000);
   // The last data bit may be kept in the same cycle the closing flag is seen.
   assign w_fcs_bad = ((w_keep ? w_crc_nxt : r_crc) != 16'hF0B8);

   // CRC accumulator: restarts at every flag or abort, steps on kept bits.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_crc <= 16'hFFFF;
      end else if (w_flag || w_abort) begin
         r_crc <= 16'hFFFF;
      end else if (w_keep) begin
         r_crc <= w_crc_nxt;
      end
   end
`else
   assign w_fcs_bad = 1'b0;
`endif

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and frame-boundary decisions; a closing flag also opens the
   // next frame, so the framer stays OPEN after reporting end of frame.
   always_comb begin
      w_state_nxt   = r_state;
      w_eof         = 1'b0;
      w_err         = 1'b0;
      w_abort_pulse = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (w_flag) begin
               w_state_nxt = S_OPEN;
            end
         end
         S_OPEN: begin
            if (w_abort) begin
               w_state_nxt   = S_HUNT;
               w_abort_pulse = 1'b1;
            end else if (w_flag) begin
               if ((w_bytes_after != 8'd0) || (w_bits_after != 3'd0)) begin
                  w_eof = 1'b1;
                  w_err = (w_bits_after != 3'd0) || (w_bytes_after < 8'd2) || w_fcs_bad;
               end
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   // Raw window plus the countdown that hides the flag's own bits from the
   // delayed data path.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_win  <= 8'h00;
         r_skip <= 4'd0;
      end else if (RxEN) begin
         r_win <= w_shift;
         if (w_flag) begin
            r_skip <= c_FLAG_BITS;
         end else if (r_skip != 4'd0) begin
            r_skip <= r_skip - 4'd1;
         end
      end
   end

   // De-stuffer and octet assembler; any flag or abort discards partial data.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_ones    <= 3'd0;
         r_shreg   <= 7'd0;
         r_bitcnt  <= 3'd0;
         r_bytecnt <= 8'd0;
      end else if (w_flag || w_abort) begin
         r_ones    <= 3'd0;
         r_bitcnt  <= 3'd0;
         r_bytecnt <= 8'd0;
      end else if (w_use) begin
         if (w_dbit) begin
            r_ones <= (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;
         end else begin
            r_ones <= 3'd0;
         end
         if (w_keep) begin
            r_shreg   <= w_byte_val[7:1];
            r_bitcnt  <= w_bits_after;
            r_bytecnt <= w_bytes_after;
         end
      end
   end

   // Output registers: single-cycle pulses, held data and held frame size.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_data     <= 8'h00;
         r_newbyte  <= 1'b0;
         r_flagdet  <= 1'b0;
         r_abortsig <= 1'b0;
         r_eof      <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= 8'h00;
      end else begin
         r_newbyte  <= w_newbyte;
         r_flagdet  <= w_flag;
         r_abortsig <= w_abort_pulse;
         r_eof      <= w_eof;
         r_err      <= w_eof && w_err;
         if (w_newbyte) begin
            r_data <= w_byte_val;
         end
         if (w_eof) begin
            r_size <= w_bytes_after;
         end
      end
   end

   assign Rx_Data        = r_data;
   assign Rx_NewByte     = r_newbyte;
   assign Rx_ValidFrame  = (r_state == S_OPEN);
   assign Rx_FlagDetect  = r_flagdet;
   assign Rx_AbortSignal = r_abortsig;
   assign Rx_EoF         = r_eof;
   assign Rx_FrameError  = r_err;
   assign Rx_FrameSize   = r_size;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdlc_rx_framer
//  Purpose  : Self-checking bench for hdlc_rx_framer. Frames are bit-stuffed
//             by the bench; expected octets and end-of-frame results are
//             queued as stimulus is driven and compared when the DUT reports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hdlc_rx_framer;

`ifdef HDLC_RX_FCS_EN
   localparam bit FCS_ON = 1'b1;
`else
   localparam bit FCS_ON = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Rx = 1'b0;
   logic       RxEN = 1'b0;
   logic [7:0] Rx_Data;
   logic       Rx_NewByte;
   logic       Rx_ValidFrame;
   logic       Rx_FlagDetect;
   logic       Rx_AbortSignal;
   logic       Rx_EoF;
   logic       Rx_FrameError;
   logic [7:0] Rx_FrameSize;

   hdlc_rx_framer dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Rx             (Rx),
      .RxEN           (RxEN),
      .Rx_Data        (Rx_Data),
      .Rx_NewByte     (Rx_NewByte),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortSignal (Rx_AbortSignal),
      .Rx_EoF         (Rx_EoF),
      .Rx_FrameError  (Rx_FrameError),
      .Rx_FrameSize   (Rx_FrameSize)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          n;
      logic [31:0] data;   // octet 0 in [7:0]
      int          size;
      bit          err;    // error expected without FCS checking
   } frame_t;

   typedef struct {
      int size;
      bit err;
   } eof_t;

   int          checks = 0;
   int          errors = 0;
   int          flag_cnt = 0;
   int          abort_cnt = 0;
   int          eof_cnt = 0;
   bit          tolerate = 1'b0;
   bit          toggle = 1'b0;
   int          st_ones = 0;
   logic [7:0]  exp_bytes[$];
   eof_t        exp_eof[$];
   frame_t      tbl[5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard side: compare reported octets and frame ends with the queues.
   always @(negedge Clk) begin
      if (Rx_FlagDetect) flag_cnt++;
      if (Rx_AbortSignal) abort_cnt++;
      if (Rx_NewByte) begin
         if (exp_bytes.size() == 0) begin
            if (!tolerate) begin
               checks++; errors++;
               $display("FAIL unexpected_byte: got %02h expected none", Rx_Data);
            end
         end else begin
            logic [7:0] e;
            e = exp_bytes.pop_front();
            chk("rx_data", int'(Rx_Data), int'(e));
         end
      end
      if (Rx_EoF) begin
         eof_cnt++;
         if (exp_eof.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_eof: got size %0d expected no eof", Rx_FrameSize);
         end else begin
            eof_t e;
            e = exp_eof.pop_front();
            chk("frame_size", int'(Rx_FrameSize), e.size);
            chk("frame_error", int'(Rx_FrameError), int'(e.err));
         end
      end
   end

   function automatic logic [15:0] crc_model(input logic [31:0] d, input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 8 * n; i++) begin
         c = {1'b0, c[15:1]} ^ ((c[0] ^ d[i]) ? 16'h8408 : 16'h0000);
      end
      return c;
   endfunction

   task automatic send_raw(input logic b);
      @(negedge Clk);
      Rx   = b;
      RxEN = 1'b1;
      if (toggle) begin
         @(negedge Clk);
         RxEN = 1'b0;
         Rx   = 1'($urandom_range(1));
      end
   endtask

   task automatic idle(input int n);
      @(negedge Clk);
      RxEN = 1'b0;
      repeat (n) @(negedge Clk);
   endtask

   task automatic send_bit_stuffed(input logic b);
      send_raw(b);
      if (b) st_ones++; else st_ones = 0;
      if (st_ones == 5) begin
         send_raw(1'b0);
         st_ones = 0;
      end
   endtask

   task automatic send_byte_stuffed(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit_stuffed(b[i]);
   endtask

   task automatic send_byte_raw(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_raw(b[i]);
      st_ones = 0;
   endtask

   task automatic send_flag();
      send_byte_raw(8'h7E);
   endtask

   task automatic send_frame(input frame_t f);
      eof_t e;
      send_flag();
      for (int i = 0; i < f.n; i++) begin
         exp_bytes.push_back(f.data[8*i +: 8]);
         send_byte_stuffed(f.data[8*i +: 8]);
      end
      e.size = f.size;
      e.err  = f.err || (FCS_ON && (crc_model(f.data, f.n) != 16'hF0B8));
      exp_eof.push_back(e);
      send_flag();
      idle(4);
   endtask

   initial begin : main
      int f0, a0, e0;
      eof_t e;

      tbl[0] = '{n: 2, data: 32'h0000_3CA5, size: 2, err: 1'b0};
      tbl[1] = '{n: 2, data: 32'h0000_1FFF, size: 2, err: 1'b0};
      tbl[2] = '{n: 1, data: 32'h0000_0042, size: 1, err: 1'b1};
      tbl[3] = '{n: 3, data: 32'h0000_FF7E, size: 3, err: 1'b0};
      tbl[4] = '{n: 4, data: 32'h3FFC_8001, size: 4, err: 1'b0};

      // Reset state
      repeat (3) @(negedge Clk);
      chk("reset_valid", int'(Rx_ValidFrame), 0);
      chk("reset_data", int'(Rx_Data), 0);
      chk("reset_size", int'(Rx_FrameSize), 0);
      chk("reset_pulses", int'({Rx_NewByte, Rx_FlagDetect, Rx_AbortSignal, Rx_EoF, Rx_FrameError}), 0);
      Rst = 1'b1;
      idle(2);

      // Opening from HUNT raises ValidFrame after the flag
      send_flag();
      idle(1);
      chk("open_valid", int'(Rx_ValidFrame), 1);

      // Table-driven frames
      for (int i = 0; i < 5; i++) send_frame(tbl[i]);

      // Twelve data bits: one octet plus four residual bits
      send_flag();
      exp_bytes.push_back(8'hA5);
      send_byte_stuffed(8'hA5);
      send_bit_stuffed(1'b1); send_bit_stuffed(1'b1);
      send_bit_stuffed(1'b0); send_bit_stuffed(1'b0);
      e.size = 1; e.err = 1'b1;
      exp_eof.push_back(e);
      send_flag();
      idle(4);

      // Back-to-back flags: three flag pulses, no end of frame
      f0 = flag_cnt; e0 = eof_cnt;
      send_flag(); send_flag(); send_flag();
      idle(4);
      chk("triple_flags", flag_cnt - f0, 3);
      chk("triple_no_eof", eof_cnt - e0, 0);

      // Abort inside a frame, then reopen
      a0 = abort_cnt; e0 = eof_cnt;
      tolerate = 1'b1;
      send_flag();
      send_byte_stuffed(8'h55);
      send_byte_raw(8'hFE);
      idle(3);
      tolerate = 1'b0;
      chk("abort_pulses", abort_cnt - a0, 1);
      chk("abort_valid", int'(Rx_ValidFrame), 0);
      chk("abort_no_eof", eof_cnt - e0, 0);
      send_flag();
      idle(1);
      chk("reopen_valid", int'(Rx_ValidFrame), 1);

      // Strobe toggling every cycle gives the same frame result
      toggle = 1'b1;
      send_frame(tbl[0]);
      toggle = 1'b0;

      // Asynchronous reset in the middle of a frame
      e0 = eof_cnt; a0 = abort_cnt;
      send_flag();
      send_byte_stuffed(8'hA5);
      @(negedge Clk);
      RxEN = 1'b0;
      #2 Rst = 1'b0;
      #1;
      chk("midrst_data", int'(Rx_Data), 0);
      chk("midrst_size", int'(Rx_FrameSize), 0);
      chk("midrst_valid", int'(Rx_ValidFrame), 0);
      chk("midrst_pulses", int'({Rx_NewByte, Rx_FlagDetect, Rx_AbortSignal, Rx_EoF, Rx_FrameError}), 0);
      @(negedge Clk);
      Rst = 1'b1;
      idle(2);
      send_flag();
      idle(3);
      chk("midrst_reopen", int'(Rx_ValidFrame), 1);
      chk("midrst_no_eof", eof_cnt - e0, 0);
      chk("midrst_no_abort", abort_cnt - a0, 0);

`ifdef HDLC_RX_FCS_EN
      begin : fcs
         frame_t      f;
         logic [15:0] fcs;
         fcs    = ~crc_model(32'h0000_0201, 2);
         f.n    = 4;
         f.data = {fcs[15:8], fcs[7:0], 8'h02, 8'h01};
         f.size = 4;
         f.err  = 1'b0;
         chk("fcs_model_residue", int'(crc_model(f.data, 4)), 32'hF0B8);
         send_frame(f);
         f.data = f.data ^ 32'h0001_0000;
         f.err  = 1'b1;
         send_frame(f);
      end
`endif

      idle(10);
      chk("bytes_left", exp_bytes.size(), 0);
      chk("eofs_left", exp_eof.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/hdlc_rx_framer.md
HDLC_RX_FRAMER -- requirements
Module: hdlc_rx_framer

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 Rst  input  1  asynchronous active-low reset; clears all state immediately on assertion.
REQ-003 Rx  input  1  serial line bit, LSB-first octets; sampled only when RxEN=1.
REQ-004 RxEN  input  1  bit strobe; RxEN=0 cycles SHALL be ignored and hold all state.
REQ-005 Rx_Data  output  8  last assembled de-stuffed octet; valid while Rx_NewByte=1.
REQ-006 Rx_NewByte  output  1  one-cycle pulse per assembled octet.
REQ-007 Rx_ValidFrame  output  1  high from opening flag until closing flag or abort.
REQ-008 Rx_FlagDetect  output  1  one-cycle pulse per detected flag (01111110).
REQ-009 Rx_AbortSignal  output  1  one-cycle pulse when abort is detected inside a frame.
REQ-010 Rx_EoF  output  1  one-cycle pulse on the closing flag of a frame with at least one octet.
REQ-011 Rx_FrameError  output  1  qualifies Rx_EoF; valid only in the Rx_EoF cycle.
REQ-012 Rx_FrameSize  output  8  octets in the completed frame, FCS included, saturating at 255; held until the next opening flag.

Function
REQ-013 A raw 8-bit window SHALL shift on every RxEN=1 cycle; flag = 0x7E pattern, abort = 7 consecutive ones.
REQ-014 The data path SHALL use the raw bit delayed by 8 sampled bits, so flag bits never reach the assembler.
REQ-015 State HUNT: no data assembly; flag detected -> OPEN, Rx_ValidFrame=1 next cycle.
REQ-016 State OPEN: delayed bits go to the de-stuffer and assembler; flag -> close frame; abort -> HUNT.
REQ-017 De-stuffing: after 5 consecutive delayed ones, a following 0 SHALL be discarded without being counted; the ones counter resets on any 0.
REQ-018 The assembler SHALL place kept bits LSB-first; after the 8th kept bit, Rx_Data and Rx_NewByte SHALL be registered on the next edge; the bit counter then wraps to 0.
REQ-019 Closing flag with 0 octets and 0 residual bits (back-to-back flags) SHALL keep OPEN, with no Rx_EoF.
REQ-020 Otherwise the closing flag SHALL pulse Rx_EoF and stay OPEN, because the shared flag opens the next frame.
REQ-021 Rx_FrameError=1 with Rx_EoF if residual bit count is nonzero (non-octet-aligned) or octet count < 2.
REQ-022 Abort in OPEN SHALL pulse Rx_AbortSignal, clear Rx_ValidFrame, and discard partial byte and count; abort in HUNT produces no pulse.
REQ-023 When a flag and an octet completion coincide, Rx_NewByte SHALL fire for that octet before, or with, Rx_EoF, and the octet SHALL be counted.

Reset
REQ-024 While Rst=0: state HUNT, window register = 0x00, all counters 0, and every output 0, including Rx_Data and Rx_FrameSize.
REQ-025 Reset mid-frame SHALL discard the frame with no Rx_EoF or Rx_AbortSignal pulse; after release, reception resumes in HUNT.

Configuration
REQ-026 Macro HDLC_RX_FCS_EN: when defined, a CRC-16-CCITT is computed over kept data bits.
  - Polynomial 0x1021, reflected, initial value 0xFFFF, re-initialised at each opening flag.
  - Rx_FrameError SHALL also assert if the residue at close is not 0xF0B8.
REQ-027 When HDLC_RX_FCS_EN is undefined, no CRC logic is built; Rx_FrameError covers only the REQ-021 conditions.

Verification
REQ-028 Flag, 0xA5, 0x3C, flag, RxEN=1 continuous -> Rx_NewByte twice with 0xA5 then 0x3C; Rx_EoF; Rx_FrameSize=2; Rx_FrameError=0 (macro off).
REQ-029 Flag, 0xFF sent stuffed as 11111 0 111, 0x1F, flag -> Rx_Data 0xFF then 0x1F; stuffed zero not counted; Rx_FrameSize=2.
REQ-030 Flag, 0x55, then 0xFE (7 ones) -> one Rx_AbortSignal pulse, Rx_ValidFrame=0, no Rx_EoF; a later flag reopens the frame.
REQ-031 Flag, 12 data bits, flag -> Rx_EoF with Rx_FrameError=1; flag, flag, flag -> 3 Rx_FlagDetect pulses, no Rx_EoF.
REQ-032 Macro on: flag, 0x01, 0x02, correct FCS (2 octets), flag -> Rx_FrameError=0, Rx_FrameSize=4; same frame with one FCS bit flipped -> Rx_FrameError=1.
REQ-033 Frame with RxEN toggled 1/0 every cycle -> same results as REQ-028; Rst pulled low after 0xA5 -> all outputs 0 at once, and no Rx_EoF for that frame.
